// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared FSM encodings and default widths for the subtract arbiter
package sub_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/sub_core.sv
// rtl/sub_core.sv - combinational a - b with unsigned borrow
module sub_core #(
    parameter int WIDTH = sub_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] sum;

    // Two's complement add at WIDTH+1 bits; a missing carry-out means a < b.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        diff   = sum[WIDTH-1:0];
        borrow = ~sum[WIDTH];
    end

endmodule

// File: rtl/sub_arbiter_8bit.sv
// rtl/sub_arbiter_8bit.sv - two-requester round-robin subtractor with registered response
module sub_arbiter_8bit
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_borrow,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic             last_q;
    logic [WIDTH-1:0] result_q;
    logic             borrow_q;
    logic             zero_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant;
    logic             accept;
    logic             rsp_done;
    logic [WIDTH-1:0] core_diff;
    logic             core_borrow;

    // One subtractor serves both requesters; it always sees the latched operands.
    sub_core #(.WIDTH(WIDTH)) u_core (
        .a      (a_q),
        .b      (b_q),
        .diff   (core_diff),
        .borrow (core_borrow)
    );

    // Round-robin grant, only offered while idle; on a tie the requester not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state_q == ST_IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign rsp_done  = (state_q == ST_RESP) && rsp_ready;

    // Next-state logic: accept -> compute one cycle -> hold response until consumed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and completion counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the granted requester's operands so later input changes cannot disturb the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            last_q <= 1'b1;
        end else if (accept) begin
            a_q    <= grant[1] ? req_a1 : req_a0;
            b_q    <= grant[1] ? req_b1 : req_b0;
            id_q   <= grant[1];
            last_q <= grant[1];
        end
    end

    // Register the arithmetic flags during EXEC; they stay frozen through RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_q <= core_diff;
            borrow_q <= core_borrow;
            zero_q   <= (core_diff == '0);
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_borrow = borrow_q;
    assign rsp_zero   = zero_q;
    assign op_count   = cnt_q;

    logic unused_done;
    assign unused_done = rsp_done;

endmodule

// File: tb/tb_sub_arbiter_8bit.sv
// tb/tb_sub_arbiter_8bit.sv - directed scoreboard bench for sub_arbiter_8bit
module tb_sub_arbiter_8bit;

    logic       clk;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [7:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_borrow;
    logic       rsp_zero;
    logic [7:0] op_count;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       bor;
        logic       zer;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic       last_m   = 1'b1;
    logic [7:0] cnt_m    = 8'd0;

    sub_arbiter_8bit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_borrow (rsp_borrow),
        .rsp_zero   (rsp_zero),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input exp_t e);
        chk({tag, "_id"},     {31'd0, rsp_id},     {31'd0, e.id});
        chk({tag, "_result"}, {24'd0, rsp_result}, {24'd0, e.res});
        chk({tag, "_borrow"}, {31'd0, rsp_borrow}, {31'd0, e.bor});
        chk({tag, "_zero"},   {31'd0, rsp_zero},   {31'd0, e.zer});
    endtask

    // Entered a little after a falling edge with the DUT idle; returns the same way.
    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid},  32'd0);
        chk("rst_rsp_id",    {31'd0, rsp_id},     32'd0);
        chk("rst_result",    {24'd0, rsp_result}, 32'd0);
        chk("rst_borrow",    {31'd0, rsp_borrow}, 32'd0);
        chk("rst_zero",      {31'd0, rsp_zero},   32'd0);
        chk("rst_op_count",  {24'd0, op_count},   32'd0);
        chk("rst_req_ready", {30'd0, req_ready},  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        cnt_m  = 8'd0;
        last_m = 1'b1;
        sb.delete();
    endtask

    task automatic run_txn(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1, input int stall);
        exp_t       e;
        logic [1:0] g;
        logic [7:0] ea, eb;
        req_valid = v;
        req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        rsp_ready = (stall == 0);
        #1;
        g = (v == 2'b11) ? (last_m ? 2'b01 : 2'b10) : v;
        chk("grant", {30'd0, req_ready}, {30'd0, g});
        ea    = g[1] ? a1 : a0;
        eb    = g[1] ? b1 : b0;
        e.id  = g[1];
        e.res = ea - eb;
        e.bor = (ea < eb);
        e.zer = (ea == eb);
        sb.push_back(e);
        last_m = g[1];
        @(negedge clk); #1;
        // In EXEC: disturb the operands; the latched ones must win.
        req_a0 = ~a0; req_b0 = a0; req_a1 = ~b1; req_b1 = a1;
        chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("exec_req_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk); #1;
        chk("resp_valid_n2", {31'd0, rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            chk_fields("stall", e);
            chk("stall_valid",     {31'd0, rsp_valid}, 32'd1);
            chk("stall_req_ready", {30'd0, req_ready}, 32'd0);
            chk("stall_op_count",  {24'd0, op_count},  {24'd0, cnt_m});
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk_fields("resp", e);
        chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk); #1;
        cnt_m = cnt_m + 8'd1;
        chk("done_op_count", {24'd0, op_count},  {24'd0, cnt_m});
        chk("done_valid",    {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [1:0] rv;
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req_a0 = 8'd0; req_b0 = 8'd0; req_a1 = 8'd0; req_b1 = 8'd0;
        @(negedge clk); #1;
        do_reset();

        // Basic subtract, borrow and zero cases.
        run_txn(2'b01, 8'd9, 8'd6, 8'd0, 8'd0, 0);
        chk("first_op_count", {24'd0, op_count}, 32'd1);
        run_txn(2'b01, 8'd2, 8'd3, 8'd0, 8'd0, 0);
        run_txn(2'b01, 8'd5, 8'd5, 8'd0, 8'd0, 0);
        run_txn(2'b10, 8'd0, 8'd0, 8'd0, 8'd255, 0);

        // Consumer stalls for five cycles.
        run_txn(2'b01, 8'd200, 8'd100, 8'd0, 8'd0, 5);

        // Round-robin from reset: ids 0,1,0,1.
        do_reset();
        for (int k = 0; k < 4; k++) run_txn(2'b11, 8'd7, 8'd3, 8'd8, 8'd2, 0);
        chk("rr_op_count", {24'd0, op_count}, 32'd4);

        // Reset during EXEC discards the operation.
        req_valid = 2'b01; req_a0 = 8'd4; req_b0 = 8'd1; rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("pre_abort_valid", {31'd0, rsp_valid}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("abort_valid",    {31'd0, rsp_valid}, 32'd0);
        chk("abort_op_count", {24'd0, op_count},  32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("abort_still_idle", {31'd0, rsp_valid}, 32'd0);
        reset_n = 1'b1;
        #1;
        cnt_m = 8'd0; last_m = 1'b1; sb.delete();
        run_txn(2'b01, 8'd4, 8'd1, 8'd0, 8'd0, 0);

        // Counter wrap: 256 completions from reset.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            rv = 2'($urandom_range(1, 3));
            run_txn(rv, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
        end
        chk("wrap_op_count", {24'd0, op_count}, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
